// File: rtl/expansion_input_filter.sv
// Per-bit debounce filter for the expansion shift-register input word.
// Publishes a stable word, sticky rise/fall flags, a change strobe and a saturating change counter.
module expansion_input_filter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SAMPLE_DIV  = 1000,
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       raw_in,
  output logic [WIDTH-1:0]       data_out,
  output logic [WIDTH-1:0]       rise,
  output logic [WIDTH-1:0]       fall,
  input  logic [WIDTH-1:0]       event_clear,
  output logic                   changed,
  output logic [COUNT_WIDTH-1:0] change_count
);

  localparam int unsigned PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PrescMax = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CntLast  = CW'(DEBOUNCE - 1);

  logic [PW-1:0]          presc_q, presc_d;
  logic [CW-1:0]          cnt_q [WIDTH];
  logic [CW-1:0]          cnt_d [WIDTH];
  logic [WIDTH-1:0]       data_q, data_d;
  logic [WIDTH-1:0]       rise_q, rise_d;
  logic [WIDTH-1:0]       fall_q, fall_d;
  logic                   changed_q, changed_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0]       accept;
  logic                   tick;

  always_comb begin
    tick    = (presc_q == '0);
    presc_d = tick ? PrescMax : presc_q - PW'(1);

    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (raw_in[i] == data_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntLast) begin
          accept[i] = 1'b1;
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    data_d = data_q ^ accept;
    // A new event in the same cycle as a clear leaves the flag set.
    rise_d = (rise_q & ~event_clear) | (accept & raw_in);
    fall_d = (fall_q & ~event_clear) | (accept & ~raw_in);

    changed_d = |accept;
    count_d   = count_q;
    if ((|accept) && (count_q != '1)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= PrescMax;
      data_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      count_q   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      data_q    <= data_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      count_q   <= count_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign data_out     = data_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign changed      = changed_q;
  assign change_count = count_q;

endmodule

// File: tb/tb_expansion_input_filter.sv
// Directed bench for expansion_input_filter: three instances cover DEBOUNCE 4/3/1 settings.
module tb_expansion_input_filter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int edges;

  // Edges since reset release; sample ticks land on edges that are multiples of SAMPLE_DIV.
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  // A: SAMPLE_DIV=4, DEBOUNCE=4, COUNT_WIDTH=16
  logic [7:0]  raw_a, data_a, rise_a, fall_a, clr_a;
  logic        chg_a;
  logic [15:0] cnt_a;
  // B: SAMPLE_DIV=4, DEBOUNCE=3, COUNT_WIDTH=4
  logic [7:0]  raw_b, data_b, rise_b, fall_b, clr_b;
  logic        chg_b;
  logic [3:0]  cnt_b;
  // C: SAMPLE_DIV=1, DEBOUNCE=1, COUNT_WIDTH=16
  logic [7:0]  raw_c, data_c, rise_c, fall_c, clr_c;
  logic        chg_c;
  logic [15:0] cnt_c;

  expansion_input_filter #(.WIDTH(8), .SAMPLE_DIV(4), .DEBOUNCE(4), .COUNT_WIDTH(16)) u_a (
    .clk(clk), .reset(reset), .raw_in(raw_a), .data_out(data_a), .rise(rise_a),
    .fall(fall_a), .event_clear(clr_a), .changed(chg_a), .change_count(cnt_a)
  );
  expansion_input_filter #(.WIDTH(8), .SAMPLE_DIV(4), .DEBOUNCE(3), .COUNT_WIDTH(4)) u_b (
    .clk(clk), .reset(reset), .raw_in(raw_b), .data_out(data_b), .rise(rise_b),
    .fall(fall_b), .event_clear(clr_b), .changed(chg_b), .change_count(cnt_b)
  );
  expansion_input_filter #(.WIDTH(8), .SAMPLE_DIV(1), .DEBOUNCE(1), .COUNT_WIDTH(16)) u_c (
    .clk(clk), .reset(reset), .raw_in(raw_c), .data_out(data_c), .rise(rise_c),
    .fall(fall_c), .event_clear(clr_c), .changed(chg_c), .change_count(cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge following posedge number k.
  task automatic to_edge(input int k);
    while (edges < k) @(negedge clk);
  endtask

  initial begin
    raw_a = 8'hFF; raw_b = 8'h00; raw_c = 8'h00;
    clr_a = 8'h00; clr_b = 8'h00; clr_c = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_a", {24'd0, data_a}, 32'h0);
    check("rst_cnt_a", {16'd0, cnt_a}, 32'h0);
    reset = 1'b0;

    // 1: all-high input after reset
    check("t1_data0", {24'd0, data_a}, 32'h0);
    check("t1_rise0", {24'd0, rise_a}, 32'h0);
    check("t1_fall0", {24'd0, fall_a}, 32'h0);
    check("t1_chg0", {31'd0, chg_a}, 32'h0);
    check("t1_cnt0", {16'd0, cnt_a}, 32'h0);
    check("c_rst_data", {24'd0, data_c}, 32'h0);

    // C: DEBOUNCE=1, tick every cycle
    to_edge(1);
    raw_c = 8'hA5;
    to_edge(2);
    check("c_data1", {24'd0, data_c}, 32'hA5);
    check("c_rise1", {24'd0, rise_c}, 32'hA5);
    check("c_chg1", {31'd0, chg_c}, 32'h1);
    check("c_cnt1", {16'd0, cnt_c}, 32'h1);
    raw_c = 8'h0F;
    to_edge(3);
    check("c_data2", {24'd0, data_c}, 32'h0F);
    check("c_rise2", {24'd0, rise_c}, 32'hAF);
    check("c_fall2", {24'd0, fall_c}, 32'hA0);
    check("c_cnt2", {16'd0, cnt_c}, 32'h2);

    to_edge(15);
    check("t1_data_pre", {24'd0, data_a}, 32'h0);
    to_edge(16);
    check("t1_data", {24'd0, data_a}, 32'hFF);
    check("t1_rise", {24'd0, rise_a}, 32'hFF);
    check("t1_fall", {24'd0, fall_a}, 32'h0);
    check("t1_chg", {31'd0, chg_a}, 32'h1);
    check("t1_cnt", {16'd0, cnt_a}, 32'h1);
    to_edge(17);
    check("t1_chg_off", {31'd0, chg_a}, 32'h0);

    // 2: raw_b[0] rises; ticks at 20,24,28
    raw_b[0] = 1'b1;
    to_edge(27);
    check("t2_data_pre", {24'd0, data_b}, 32'h0);
    check("t2_chg_pre", {31'd0, chg_b}, 32'h0);
    to_edge(28);
    check("t2_data", {24'd0, data_b}, 32'h01);
    check("t2_rise", {24'd0, rise_b}, 32'h01);
    check("t2_chg", {31'd0, chg_b}, 32'h1);
    check("t2_cnt", {28'd0, cnt_b}, 32'h1);
    to_edge(29);
    check("t2_chg_off", {31'd0, chg_b}, 32'h0);

    // 3: glitch on raw_b[1] for ticks 32,36 only
    raw_b[1] = 1'b1;
    to_edge(36);
    raw_b[1] = 1'b0;
    to_edge(44);
    check("t3_data", {24'd0, data_b}, 32'h01);
    check("t3_rise", {24'd0, rise_b}, 32'h01);
    check("t3_cnt", {28'd0, cnt_b}, 32'h1);

    // 4: set beats a held clear on bit 5; ticks 48,52,56
    raw_b[5] = 1'b1;
    clr_b[5] = 1'b1;
    to_edge(55);
    check("t4_rise_pre", {24'd0, rise_b}, 32'h01);
    to_edge(56);
    check("t4_rise_set", {24'd0, rise_b}, 32'h21);
    check("t4_data", {24'd0, data_b}, 32'h21);
    check("t4_cnt", {28'd0, cnt_b}, 32'h2);
    to_edge(57);
    check("t4_rise_clr", {24'd0, rise_b}, 32'h01);
    clr_b = 8'h00;

    // 5: 20 toggles of raw_b[2], each accepted 11 edges after the toggle
    for (int k = 0; k < 20; k++) begin
      raw_b[2] = ~raw_b[2];
      to_edge(68 + 12 * k);
      if (k == 11) check("t5_cnt14", {28'd0, cnt_b}, 32'hE);
      if (k == 12) check("t5_cnt15", {28'd0, cnt_b}, 32'hF);
      to_edge(69 + 12 * k);
    end
    check("t5_cnt_sat", {28'd0, cnt_b}, 32'hF);
    check("t5_rise", {31'd0, rise_b[2]}, 32'h1);
    check("t5_fall", {31'd0, fall_b[2]}, 32'h1);
    check("t5_data", {24'd0, data_b}, 32'h21);

    // 6: reset after 2 of 3 ticks on raw_b[3]; ticks at 300,304
    raw_b[3] = 1'b1;
    to_edge(305);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_data", {24'd0, data_b}, 32'h0);
    check("t6_rst_rise", {24'd0, rise_b}, 32'h0);
    check("t6_rst_fall", {24'd0, fall_b}, 32'h0);
    check("t6_rst_cnt", {28'd0, cnt_b}, 32'h0);
    reset = 1'b0;
    to_edge(4);
    check("t6_data_t1", {24'd0, data_b}, 32'h0);
    to_edge(11);
    check("t6_data_pre", {24'd0, data_b}, 32'h0);
    to_edge(12);
    check("t6_data", {24'd0, data_b}, 32'h29);
    check("t6_cnt", {28'd0, cnt_b}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
